// File: rtl/mvmu_pkg.sv
// Shared definitions for the matrix-vector multiply unit: FSM encoding,
// shift-control width and a width helper usable in constant expressions.
package mvmu_pkg;

  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1, so it can size index ports directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mvmu_dot.sv
// One row of the matrix-vector product: COLS-wide dot product, right shift,
// saturation and optional accumulation onto the previous row result.
module mvmu_dot
  import mvmu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + clog2(COLS) + 1
) (
  input  logic [COLS*DATA_WIDTH-1:0] w_row,
  input  logic [COLS*DATA_WIDTH-1:0] vec,
  input  logic                       is_signed,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic                       acc_en,
  input  logic [DATA_WIDTH-1:0]      prev,
  output logic [DATA_WIDTH-1:0]      result
);

  localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;
  localparam logic signed [ACC_WIDTH-1:0] UMAX = ACC_WIDTH'((2**DATA_WIDTH) - 1);

  function automatic logic signed [ACC_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] v,
                                                       input logic s);
    return {{(ACC_WIDTH-DATA_WIDTH){s & v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] x,
                                                input logic s);
    logic [DATA_WIDTH-1:0] r;
    if (s) begin
      if (x > SMAX)      r = SMAX[DATA_WIDTH-1:0];
      else if (x < SMIN) r = SMIN[DATA_WIDTH-1:0];
      else               r = x[DATA_WIDTH-1:0];
    end else begin
      if (x[ACC_WIDTH-1]) r = '0;
      else if (x > UMAX)  r = '1;
      else                r = x[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] total;
  logic [DATA_WIDTH-1:0]       quant;

  always_comb begin
    acc = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = acc + ext(w_row[c*DATA_WIDTH +: DATA_WIDTH], is_signed)
                * ext(vec[c*DATA_WIDTH +: DATA_WIDTH], is_signed);
    end

    // Oversized shifts collapse to the fill value instead of wrapping.
    if (int'(shift) >= ACC_WIDTH) begin
      shifted = is_signed ? {ACC_WIDTH{acc[ACC_WIDTH-1]}} : '0;
    end else if (is_signed) begin
      shifted = acc >>> shift;
    end else begin
      shifted = acc >> shift;
    end

    quant  = sat(shifted, is_signed);
    total  = ext(prev, is_signed) + ext(quant, is_signed);
    result = acc_en ? sat(total, is_signed) : quant;
  end

endmodule

// File: rtl/mvmu_array.sv
// Weight-stationary matrix-vector multiply unit, one output row per cycle.
//   state     | meaning
//   S_IDLE    | accepts weight writes, clear and a new input vector
//   S_COMPUTE | evaluates row row_q and writes it into out_vec
//   S_DONE    | holds out_vec/out_valid until out_ready
module mvmu_array
  import mvmu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 32,
  parameter int COLS       = 32
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       wr_en,
  input  logic [clog2(ROWS)-1:0]     wr_row,
  input  logic [COLS*DATA_WIDTH-1:0] wr_data,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COLS*DATA_WIDTH-1:0] in_vec,
  input  logic                       cfg_signed,
  input  logic [SHIFT_W-1:0]         cfg_shift,
  input  logic                       cfg_acc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROWS*DATA_WIDTH-1:0] out_vec,
  output logic                       busy,
  output logic [63:0]                work_cnt
);

  localparam int ACC_WIDTH = 2*DATA_WIDTH + clog2(COLS) + 1;
  localparam int ROW_W     = clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t                     state_q, state_d;
  logic                       init_q;
  logic [ROW_W-1:0]           row_q;
  logic [COLS*DATA_WIDTH-1:0] in_vec_q;
  logic                       sgn_q;
  logic [SHIFT_W-1:0]         shift_q;
  logic                       acc_q;
  logic [ROWS*DATA_WIDTH-1:0] out_vec_q;
  logic [63:0]                work_cnt_q;
  logic [COLS*DATA_WIDTH-1:0] weight_q [ROWS];

  logic                       in_fire, out_fire, wr_fire, clr_fire, computing;
  logic [DATA_WIDTH-1:0]      row_res;

  // init_q keeps in_ready low until the first clock after reset release.
  assign in_ready  = (state_q == S_IDLE) && init_q && !clr && !wr_en;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_fire  = out_valid && out_ready;
  assign clr_fire  = (state_q == S_IDLE) && clr;
  assign wr_fire   = (state_q == S_IDLE) && wr_en && !clr;
  assign computing = (state_q == S_COMPUTE);
  assign busy      = (state_q != S_IDLE);
  assign out_vec   = out_vec_q;
  assign work_cnt  = work_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_fire) state_d = S_COMPUTE;
      S_COMPUTE: if (row_q == LAST_ROW) state_d = S_DONE;
      S_DONE:    if (out_fire) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  mvmu_dot #(
    .DATA_WIDTH (DATA_WIDTH),
    .COLS       (COLS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_dot (
    .w_row     (weight_q[row_q]),
    .vec       (in_vec_q),
    .is_signed (sgn_q),
    .shift     (shift_q),
    .acc_en    (acc_q),
    .prev      (out_vec_q[row_q*DATA_WIDTH +: DATA_WIDTH]),
    .result    (row_res)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      init_q     <= 1'b0;
      row_q      <= '0;
      in_vec_q   <= '0;
      sgn_q      <= 1'b0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      out_vec_q  <= '0;
      work_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (in_fire) begin
        in_vec_q <= in_vec;
        sgn_q    <= cfg_signed;
        shift_q  <= cfg_shift;
        acc_q    <= cfg_acc;
        row_q    <= '0;
      end
      if (computing) begin
        out_vec_q[row_q*DATA_WIDTH +: DATA_WIDTH] <= row_res;
        row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end
      if (wr_fire || computing) begin
        work_cnt_q <= work_cnt_q + 64'd1;
      end
    end
  end

  // Weights survive reset; only clr in IDLE zeroes them.
  always_ff @(posedge clk) begin
    if (clr_fire) begin
      for (int r = 0; r < ROWS; r++) weight_q[r] <= '0;
    end else if (wr_fire) begin
      weight_q[wr_row] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mvmu_array.sv
// Self-checking bench for mvmu_array with ROWS=COLS=4, DATA_WIDTH=8.
module tb_mvmu_array;
  import mvmu_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            RST;
  logic            wr_en;
  logic [1:0]      wr_row;
  logic [31:0]     wr_data;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_vec;
  logic            cfg_signed;
  logic [4:0]      cfg_shift;
  logic            cfg_acc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_vec;
  logic            busy;
  logic [63:0]     work_cnt;

  mvmu_array #(.DATA_WIDTH(DW), .ROWS(NR), .COLS(NC)) dut (
    .clk        (clk),
    .RST        (RST),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .cfg_signed (cfg_signed),
    .cfg_shift  (cfg_shift),
    .cfg_acc    (cfg_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .busy       (busy),
    .work_cnt   (work_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] wts;
    logic [31:0]  vin;
    logic         sgn;
    logic [4:0]   sh;
    logic         acc;
    logic [31:0]  exp;
  } vec_t;

  // Weight images: {row3, row2, row1, row0}, column 0 in the low byte.
  localparam logic [127:0] W_IDENT = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
  localparam logic [127:0] W_NEG   = {32'h0, 32'h0, 32'h0, 32'h80808080};
  localparam logic [127:0] W_POS   = {32'h0, 32'h0, 32'h0, 32'h7F7F7F7F};
  localparam logic [127:0] W_MIX   = {32'h03000000, 32'h000000FF, 32'h00000002, 32'h01010101};
  localparam logic [127:0] W_TILE  = {32'h0, 32'h0, 32'h0, 32'h19191919};

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  vec_t        tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [127:0] w);
    for (int r = 0; r < NR; r++) begin
      wr_en   = 1'b1;
      wr_row  = 2'(r);
      wr_data = w[r*32 +: 32];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input logic s, input logic [4:0] sh,
                      input logic a, input logic [31:0] e, input logic push);
    int n;
    in_vec     = v;
    cfg_signed = s;
    cfg_shift  = sh;
    cfg_acc    = a;
    in_valid   = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  task automatic collect(input string name);
    int n;
    logic [31:0] e;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (exp_q.size() == 0) begin
      chk({name, "_sb_underflow"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      if (!out_valid) chk({name, "_timeout"}, {63'd0, out_valid}, 64'd1);
      else            chk(name, {32'd0, out_vec}, {32'd0, e});
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    logic [63:0] wc0;
    int          rose;

    tbl[0]  = '{W_NEG,  32'h80808080, 1'b1, 5'd0,  1'b0, 32'h0000007F};
    tbl[1]  = '{W_NEG,  32'h80808080, 1'b1, 5'd16, 1'b0, 32'h00000001};
    tbl[2]  = '{W_NEG,  32'h80808080, 1'b0, 5'd9,  1'b0, 32'h00000080};
    tbl[3]  = '{W_NEG,  32'h80808080, 1'b0, 5'd0,  1'b0, 32'h000000FF};
    tbl[4]  = '{W_NEG,  32'h01010101, 1'b1, 5'd20, 1'b0, 32'h000000FF};
    tbl[5]  = '{W_NEG,  32'h01010101, 1'b1, 5'd3,  1'b0, 32'h000000C0};
    tbl[6]  = '{W_NEG,  32'h01010101, 1'b0, 5'd25, 1'b0, 32'h00000000};
    tbl[7]  = '{W_POS,  32'h80808080, 1'b1, 5'd0,  1'b0, 32'h00000080};
    tbl[8]  = '{W_MIX,  32'h281E140A, 1'b1, 5'd0,  1'b0, 32'h78F61464};
    tbl[9]  = '{W_MIX,  32'h281E140A, 1'b0, 5'd0,  1'b0, 32'h78FF1464};
    tbl[10] = '{W_MIX,  32'h281E140A, 1'b1, 5'd2,  1'b0, 32'h1EFD0519};
    tbl[11] = '{W_TILE, 32'h01010101, 1'b1, 5'd0,  1'b0, 32'h00000064};
    tbl[12] = '{W_TILE, 32'h01010101, 1'b1, 5'd0,  1'b1, 32'h0000007F};
    tbl[13] = '{W_TILE, 32'h01010101, 1'b0, 5'd0,  1'b0, 32'h00000064};
    tbl[14] = '{W_TILE, 32'h01010101, 1'b0, 5'd0,  1'b1, 32'h000000C8};

    RST = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; clr = 1'b0;
    in_valid = 1'b0; in_vec = '0; cfg_signed = 1'b0; cfg_shift = '0; cfg_acc = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_vec",   {32'd0, out_vec},   64'd0);
    chk("rst_work_cnt",  work_cnt,           64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    RST = 1'b0;
    #1;
    chk("post_rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    tick();
    chk("post_rst_in_ready_high", {63'd0, in_ready}, 64'd1);

    // Identity with output latency
    load_w(W_IDENT);
    chk("wcnt_after_writes", work_cnt, 64'd4);
    send(32'h04030201, 1'b0, 5'd0, 1'b0, 32'h04030201, 1'b1);
    chk("lat_busy", {63'd0, busy}, 64'd1);
    chk("lat_c0", {63'd0, out_valid}, 64'd0);
    for (int k = 1; k < NR; k++) begin
      tick();
      chk($sformatf("lat_c%0d", k), {63'd0, out_valid}, 64'd0);
    end
    tick();
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    collect("identity");
    chk("wcnt_after_compute", work_cnt, 64'd8);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      load_w(tbl[i].wts);
      send(tbl[i].vin, tbl[i].sgn, tbl[i].sh, tbl[i].acc, tbl[i].exp, 1'b1);
      collect($sformatf("vec%0d", i));
    end

    // Backpressure; write during DONE must be ignored
    load_w(W_IDENT);
    out_ready = 1'b0;
    send(32'h08070605, 1'b0, 5'd0, 1'b0, 32'h08070605, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        tick();
        n++;
      end
    end
    held = exp_q.pop_front();
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_first", {32'd0, out_vec}, {32'd0, held});
    wc0 = work_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        wr_en = 1'b1; wr_row = 2'd0; wr_data = 32'h09090909;
      end
      tick();
      wr_en = 1'b0;
      chk($sformatf("bp_vec%0d", i),   {32'd0, out_vec},   {32'd0, held});
      chk($sformatf("bp_rdy%0d", i),   {63'd0, in_ready},  64'd0);
      chk($sformatf("bp_busy%0d", i),  {63'd0, busy},      64'd1);
      chk($sformatf("bp_valid%0d", i), {63'd0, out_valid}, 64'd1);
    end
    chk("bp_wcnt", work_cnt, wc0);
    out_ready = 1'b1;
    tick();
    chk("bp_release_busy", {63'd0, busy}, 64'd0);
    chk("bp_hold_idle", {32'd0, out_vec}, {32'd0, held});
    send(32'h04030201, 1'b0, 5'd0, 1'b0, 32'h04030201, 1'b1);
    collect("bp_weights_kept");

    // clr and wr_en together: clear wins, write dropped
    load_w(W_MIX);
    wc0 = work_cnt;
    clr = 1'b1; wr_en = 1'b1; wr_row = 2'd1; wr_data = 32'h05050505;
    #1;
    chk("clr_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_wcnt", work_cnt, wc0);
    send(32'h281E140A, 1'b1, 5'd0, 1'b0, 32'h00000000, 1'b1);
    collect("clr_out_zero");

    // Reset while row 2 is being computed
    load_w(W_MIX);
    send(32'h281E140A, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk("mid_busy", {63'd0, busy}, 64'd1);
    RST = 1'b1;
    #1;
    chk("abort_valid",    {63'd0, out_valid}, 64'd0);
    chk("abort_out_vec",  {32'd0, out_vec},   64'd0);
    chk("abort_busy",     {63'd0, busy},      64'd0);
    chk("abort_work_cnt", work_cnt,           64'd0);
    chk("abort_in_ready", {63'd0, in_ready},  64'd0);
    tick();
    tick();
    RST = 1'b0;
    rose = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) rose++;
    end
    chk("abort_no_valid", 64'(rose), 64'd0);
    send(32'h281E140A, 1'b1, 5'd0, 1'b0, 32'h78F61464, 1'b1);
    collect("abort_weights_kept");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
